decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: circular instruction FIFO feeding a registered RV32I decode stage.
// Defining DECODE_ILLEGAL_EN adds the registered out_illegal flag.
module decode_queue #(
    parameter int DEPTH      = 8,
    parameter int OPENUM_LEN = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [31:0]           in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPENUM_LEN-1:0] out_openum,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [31:0]           out_imm,
`ifdef DECODE_ILLEGAL_EN
    output logic                  out_illegal,
`endif
    output logic [31:0]           out_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [OPENUM_LEN-1:0] op_t;

    // Immediate shifts share the register shift codes; the shamt rides in imm[4:0].
    localparam op_t OP_NOP   = op_t'(0);
    localparam op_t OP_LUI   = op_t'(1);
    localparam op_t OP_AUIPC = op_t'(2);
    localparam op_t OP_JAL   = op_t'(3);
    localparam op_t OP_JALR  = op_t'(4);
    localparam op_t OP_BEQ   = op_t'(5);
    localparam op_t OP_BNE   = op_t'(6);
    localparam op_t OP_BLT   = op_t'(7);
    localparam op_t OP_BGE   = op_t'(8);
    localparam op_t OP_BLTU  = op_t'(9);
    localparam op_t OP_BGEU  = op_t'(10);
    localparam op_t OP_LB    = op_t'(11);
    localparam op_t OP_LH    = op_t'(12);
    localparam op_t OP_LW    = op_t'(13);
    localparam op_t OP_LBU   = op_t'(14);
    localparam op_t OP_LHU   = op_t'(15);
    localparam op_t OP_SB    = op_t'(16);
    localparam op_t OP_SH    = op_t'(17);
    localparam op_t OP_SW    = op_t'(18);
    localparam op_t OP_ADDI  = op_t'(19);
    localparam op_t OP_SLTI  = op_t'(20);
    localparam op_t OP_SLTIU = op_t'(21);
    localparam op_t OP_XORI  = op_t'(22);
    localparam op_t OP_ORI   = op_t'(23);
    localparam op_t OP_ANDI  = op_t'(24);
    localparam op_t OP_ADD   = op_t'(25);
    localparam op_t OP_SUB   = op_t'(26);
    localparam op_t OP_SLL   = op_t'(27);
    localparam op_t OP_SLT   = op_t'(28);
    localparam op_t OP_SLTU  = op_t'(29);
    localparam op_t OP_XOR   = op_t'(30);
    localparam op_t OP_SRL   = op_t'(31);
    localparam op_t OP_SRA   = op_t'(32);
    localparam op_t OP_OR    = op_t'(33);
    localparam op_t OP_AND   = op_t'(34);

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          push;
    logic          load;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready && rdy_in && !flush_in;
    assign load     = (count != '0) && (!out_valid || out_ready) && rdy_in && !flush_in;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_inst[tail] <= in_inst;
            mem_pc[tail]   <= in_pc;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (load) head <= head + 1'b1;
                case ({push, load})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] sel_imm;
    logic [31:0] dec_imm;
    op_t         dec_op;

    assign inst   = mem_inst[head];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec_op  = OP_NOP;
        sel_imm = '0;
        case (opcode)
            7'b0110111: begin dec_op = OP_LUI;   sel_imm = imm_u; end
            7'b0010111: begin dec_op = OP_AUIPC; sel_imm = imm_u; end
            7'b1101111: begin dec_op = OP_JAL;   sel_imm = imm_j; end
            7'b1100111: begin
                sel_imm = imm_i;
                if (funct3 == 3'b000) dec_op = OP_JALR;
            end
            7'b1100011: begin
                sel_imm = imm_b;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0000011: begin
                sel_imm = imm_i;
                case (funct3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0100011: begin
                sel_imm = imm_s;
                case (funct3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0010011: begin
                sel_imm = imm_i;
                case (funct3)
                    3'b000:  dec_op = OP_ADDI;
                    3'b010:  dec_op = OP_SLTI;
                    3'b011:  dec_op = OP_SLTIU;
                    3'b100:  dec_op = OP_XORI;
                    3'b110:  dec_op = OP_ORI;
                    3'b111:  dec_op = OP_ANDI;
                    3'b001:  if (funct7 == 7'b0000000) dec_op = OP_SLL;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec_op = OP_SRL;
                        else if (funct7 == 7'b0100000) dec_op = OP_SRA;
                    end
                    default: dec_op = OP_NOP;
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  dec_op = OP_SUB;
                        3'b101:  dec_op = OP_SRA;
                        default: dec_op = OP_NOP;
                    endcase
                end
            end
            default: dec_op = OP_NOP;
        endcase
    end

    // Every undecodable pattern collapses to NOP with a zero immediate.
    assign dec_imm = (dec_op == OP_NOP) ? '0 : sel_imm;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid  <= 1'b0;
            out_openum <= OP_NOP;
            out_rd     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid  <= 1'b1;
                out_openum <= dec_op;
                out_rd     <= inst[11:7];
                out_rs1    <= inst[19:15];
                out_rs2    <= inst[24:20];
                out_imm    <= dec_imm;
                out_pc     <= mem_pc[head];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DECODE_ILLEGAL_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_illegal <= 1'b0;
        end else if (load) begin
            out_illegal <= (dec_op == OP_NOP);
        end
    end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Randomized scoreboard bench for decode_queue with a mnemonic-level reference decoder.
// Directed sequences cover latency, full, flush, stall, reset and illegal-flag cases.
module tb_decode_queue;
    localparam int DEPTH = 8;
    localparam int OL    = 6;

    localparam int T_NOP = 0, T_LUI = 1, T_AUIPC = 2, T_JAL = 3, T_JALR = 4;
    localparam int T_BEQ = 5, T_SRA = 32, T_SLL = 27, T_SRL = 31, T_SUB = 26, T_ADDI = 19;
    localparam int BR_TAB  [8] = '{5, 6, 0, 0, 7, 8, 9, 10};
    localparam int LD_TAB  [8] = '{11, 12, 13, 0, 14, 15, 0, 0};
    localparam int ST_TAB  [8] = '{16, 17, 18, 0, 0, 0, 0, 0};
    localparam int OPI_TAB [8] = '{19, 0, 20, 21, 22, 0, 23, 24};
    localparam int R_TAB   [8] = '{25, 27, 28, 29, 30, 31, 33, 34};
    localparam logic [6:0] OPS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_inst, in_pc, out_imm, out_pc;
    logic [OL-1:0] out_openum;
    logic [4:0]    out_rd, out_rs1, out_rs2;
    logic          out_illegal;

    decode_queue #(.DEPTH(DEPTH), .OPENUM_LEN(OL)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_openum(out_openum),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
`ifdef DECODE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .out_pc(out_pc)
    );
`ifndef DECODE_ILLEGAL_EN
    assign out_illegal = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   op, imm;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = inst[14:12];
        f7 = inst[31:25];
        op = T_NOP;
        imm = 0;
        case (inst[6:0])
            7'h37: begin op = T_LUI;   imm = int'(inst & 32'hFFFF_F000); end
            7'h17: begin op = T_AUIPC; imm = int'(inst & 32'hFFFF_F000); end
            7'h6F: begin
                op = T_JAL;
                imm = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
                      - (inst[31] ? (1 << 20) : 0);
            end
            7'h67: begin if (f3 == 0) op = T_JALR; imm = $signed(inst) >>> 20; end
            7'h63: begin
                op = BR_TAB[f3];
                imm = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
                      - (inst[31] ? 4096 : 0);
            end
            7'h03: begin op = LD_TAB[f3]; imm = $signed(inst) >>> 20; end
            7'h23: begin op = ST_TAB[f3]; imm = ($signed(inst) >>> 25) * 32 + int'(inst[11:7]); end
            7'h13: begin
                imm = $signed(inst) >>> 20;
                if (f3 == 1)      op = (f7 == 0) ? T_SLL : T_NOP;
                else if (f3 == 5) op = (f7 == 0) ? T_SRL : (f7 == 7'h20) ? T_SRA : T_NOP;
                else              op = OPI_TAB[f3];
            end
            7'h33: begin
                if (f7 == 0)          op = R_TAB[f3];
                else if (f7 == 7'h20) op = (f3 == 0) ? T_SUB : (f3 == 5) ? T_SRA : T_NOP;
            end
            default: op = T_NOP;
        endcase
        if (op == T_NOP) imm = 0;
        e.op  = 6'(op);
        e.rd  = inst[11:7];
        e.rs1 = inst[19:15];
        e.rs2 = inst[24:20];
        e.imm = 32'(imm);
        e.pc  = pc;
        e.ill = (op == T_NOP);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            r[6:0] = OPS[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    // Issue side: record the expected decode for every accepted push.
    always @(negedge clk) begin
        if (rst_n && rdy_in && !flush_in && in_valid && in_ready)
            sb.push_back(ref_decode(in_inst, in_pc));
    end

    // Monitor: pops on every dispatch handshake and checks stall stability.
    exp_t held;
    logic hold_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_fields", {out_openum, out_rd, out_rs1, out_rs2, out_illegal},
                      {held.op, held.rd, held.rs1, held.rs2, held.ill});
                check("stall_imm", out_imm, held.imm);
                check("stall_pc", out_pc, held.pc);
            end
            if (rdy_in && flush_in) begin
                sb.delete();
                hold_v = 1'b0;
            end else if (out_valid && out_ready && rdy_in) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h, required no output (t=%0t)", out_pc, $time);
                end else begin
                    e = sb.pop_front();
                    check("openum", 32'(out_openum), 32'(e.op));
                    check("regs", {out_rd, out_rs1, out_rs2}, {e.rd, e.rs1, e.rs2});
                    check("imm", out_imm, e.imm);
                    check("pc", out_pc, e.pc);
`ifdef DECODE_ILLEGAL_EN
                    check("illegal", 32'(out_illegal), 32'(e.ill));
`endif
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                held = '{op: out_openum, rd: out_rd, rs1: out_rs1, rs2: out_rs2,
                         imm: out_imm, pc: out_pc, ill: out_illegal};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 4;
        to_drive();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1; in_valid = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 4 * DEPTH + 20) begin
            to_drive();
            n++;
        end
        check(name, 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'hDEAD_0000;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_openum", 32'(out_openum), 32'(T_NOP));
        check("rst_regs", {out_rd, out_rs1, out_rs2}, 32'd0);
        check("rst_imm", out_imm, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (2) to_drive();

        // Minimum latency: nothing visible after the push edge, valid one edge later.
        push(32'h0050_0093);
        @(negedge clk);
        check("no_bypass", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat1_valid", 32'(out_valid), 32'd1);
        check("addi_openum", 32'(out_openum), 32'(T_ADDI));
        check("addi_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd0});
        check("addi_imm", out_imm, 32'd5);
        to_drive();
        drain("drain_addi");

        // Full: the first entry occupies the output stage, so DEPTH+1 pushes fill the queue.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == DEPTH) check("ready_before_full", 32'(in_ready), 32'd1);
            push(gen_inst());
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        push(32'h0000_0013);
        check("full_ignored", 32'(in_ready), 32'd0);
        check("full_sb_len", 32'(sb.size()), 32'(DEPTH + 1));
        drain("drain_full");

        // Branch immediate and arithmetic shift immediate.
        out_ready = 1'b0;
        push(32'hFE00_0EE3);
        push(32'h4030_D093);
        @(negedge clk);
        check("beq_openum", 32'(out_openum), 32'(T_BEQ));
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        to_drive();
        @(negedge clk);
        check("srai_openum", 32'(out_openum), 32'(T_SRA));
        check("srai_shamt", 32'(out_imm[4:0]), 32'd3);
        to_drive();
        drain("drain_shift");

        // Flush with entries queued and a concurrent push.
        out_ready = 1'b0;
        repeat (4) push(gen_inst());
        check("pre_flush_valid", 32'(out_valid), 32'd1);
        flush_in = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'hBAD0_0000;
        to_drive();
        flush_in = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) to_drive();
        @(negedge clk);
        check("flush_stays_empty", 32'(out_valid), 32'd0);
        to_drive();
        push(gen_inst());
        drain("drain_flush");

        // Global stall: nothing may move while rdy_in is low.
        out_ready = 1'b0;
        repeat (3) push(gen_inst());
        rdy_in = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_inst = gen_inst(); in_pc = 32'hBAD0_0004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd1);
            to_drive();
        end
        in_valid = 1'b0; rdy_in = 1'b1;
        drain("drain_stall");

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        repeat (4) push(gen_inst());
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        check("async_rst_pc", out_pc, 32'd0);
        to_drive();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'h0000_0537);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_first_pc", out_pc, pc_ctr - 4);
        to_drive();
        drain("drain_reset");

`ifdef DECODE_ILLEGAL_EN
        out_ready = 1'b0;
        push(32'h0000_007F);
        @(negedge clk);
        check("ill_openum", 32'(out_openum), 32'(T_NOP));
        check("ill_imm", out_imm, 32'd0);
        check("ill_flag", 32'(out_illegal), 32'd1);
        drain("drain_illegal");
`endif

        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = gen_inst();
            in_pc     = pc_ctr;
            pc_ctr    = pc_ctr + 4;
            out_ready = ($urandom_range(0, 3) != 0);
            rdy_in    = ($urandom_range(0, 7) != 0);
            flush_in  = ($urandom_range(0, 63) == 0);
            to_drive();
        end
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
